pcie_msi_arb: RTL and testbench



---
 rtl/pcie_msi_arb.sv | 201 ++++++++++++++++++++
 tb/tb_pcie_msi_arb.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pcie_msi_arb.sv
// Purpose: MSI generator; captures up to 32 interrupt sources (edge or level), masks and
//          round-robin arbitrates them, and folds them onto the host-granted vector count.
// Latency: irq change -> irq_pending after 1 edge -> app_msi_req after the next edge.
// Backpressure: app_msi_req/app_msi_num are held until app_msi_ack; new events keep pending.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   irq, irq_mask         source lines (synchronous to clk), per-source mask (1 = masked)
//   msi_enable, msi_mme   config-space MSI Enable and Multiple Message Enable
//   app_msi_*             hard IP MSI request/number/traffic-class/acknowledge
//   app_int_sts/ack       legacy INTx, status tied low, ack ignored
//   irq_pending           pending bits for status/debug
//
// Optional build macro: PCIE_MSI_ARB_HOLDOFF_EN enforces HOLDOFF_CYCLES of request-low time
// after each acknowledge.

module pcie_msi_arb #(
    parameter int          N_IRQ          = 8,
    parameter logic [31:0] IRQ_LEVEL      = 32'h0,
    parameter logic [2:0]  MSI_TC         = 3'd0,
    parameter int          HOLDOFF_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_IRQ-1:0] irq,
    input  logic [N_IRQ-1:0] irq_mask,
    input  logic             msi_enable,
    input  logic [2:0]       msi_mme,
    output logic             app_msi_req,
    output logic [4:0]       app_msi_num,
    output logic [2:0]       app_msi_tc,
    input  logic             app_msi_ack,
    output logic             app_int_sts,
    input  logic             app_int_ack,
    output logic [N_IRQ-1:0] irq_pending
);

    localparam int PW = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;
    localparam logic [N_IRQ-1:0] LVL = IRQ_LEVEL[N_IRQ-1:0];

`ifdef PCIE_MSI_ARB_HOLDOFF_EN
    localparam int CW = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
    localparam logic [CW-1:0] HOLD_LOAD = (HOLDOFF_CYCLES > 0) ? CW'(HOLDOFF_CYCLES - 1) : '0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_HOLDOFF = 2'd2
    } state_t;

    logic [CW-1:0] cnt_q, cnt_d;
`else
    localparam int HOLDOFF_UNUSED = HOLDOFF_CYCLES;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1
    } state_t;
`endif

    state_t           state_q, state_d;
    logic [N_IRQ-1:0] irq_q, irq_d;
    logic [N_IRQ-1:0] pending_q, pending_d;
    logic             req_q, req_d;
    logic [4:0]       num_q, num_d;
    logic [PW-1:0]    ptr_q, ptr_d;

    logic [N_IRQ-1:0] set_v;
    logic [N_IRQ-1:0] clr_v;
    logic [N_IRQ-1:0] eligible;
    logic [2:0]       mme_eff;
    logic [5:0]       alloc;
    logic [4:0]       vec [N_IRQ];
    logic             found;
    logic [PW-1:0]    win;
    logic             can_issue;
    int               idx;

    logic unused_int_ack;
    assign unused_int_ack = app_int_ack;

    assign app_msi_req = req_q;
    assign app_msi_num = num_q;
    assign app_msi_tc  = MSI_TC;
    assign app_int_sts = 1'b0;
    assign irq_pending = pending_q;

    // Vector folding: sources beyond the granted count share the top granted vector.
    always_comb begin
        mme_eff = (msi_mme > 3'd5) ? 3'd5 : msi_mme;
        alloc   = 6'd1 << mme_eff;
        for (int i = 0; i < N_IRQ; i++) begin
            if (i < int'(alloc)) vec[i] = 5'(i);
            else                 vec[i] = 5'(alloc - 6'd1);
        end
    end

    // Capture and eligibility.
    always_comb begin
        irq_d    = irq;
        set_v    = (irq & LVL) | (irq & ~irq_q & ~LVL);
        eligible = pending_q & ~irq_mask & {N_IRQ{msi_enable}};
    end

    // Round-robin search starting at the pointer.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int k = 0; k < N_IRQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= N_IRQ) idx = idx - N_IRQ;
            if (!found && eligible[PW'(idx)]) begin
                found = 1'b1;
                win   = PW'(idx);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        num_d   = num_q;
        ptr_d   = ptr_q;
        clr_v   = '0;
`ifdef PCIE_MSI_ARB_HOLDOFF_EN
        cnt_d     = cnt_q;
        // The final holdoff cycle also acts as the idle decision cycle, so the request
        // line stays low for exactly HOLDOFF_CYCLES cycles after an ack.
        can_issue = (state_q == ST_IDLE) || ((state_q == ST_HOLDOFF) && (cnt_q == '0));
`else
        can_issue = (state_q == ST_IDLE);
`endif

        case (state_q)
            ST_REQ: begin
                if (app_msi_ack) begin
                    // Clear every source folded onto the vector just acknowledged,
                    // evaluated with the mapping in force now.
                    for (int i = 0; i < N_IRQ; i++) begin
                        clr_v[i] = (vec[i] == num_q);
                    end
                    req_d = 1'b0;
`ifdef PCIE_MSI_ARB_HOLDOFF_EN
                    if (HOLDOFF_CYCLES > 0) begin
                        state_d = ST_HOLDOFF;
                        cnt_d   = HOLD_LOAD;
                    end else begin
                        state_d = ST_IDLE;
                    end
`else
                    state_d = ST_IDLE;
`endif
                end
            end
`ifdef PCIE_MSI_ARB_HOLDOFF_EN
            ST_HOLDOFF: begin
                if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
                else             state_d = ST_IDLE;
            end
`endif
            default: ;
        endcase

        if (can_issue && found) begin
            req_d   = 1'b1;
            num_d   = vec[win];
            state_d = ST_REQ;
            if (int'(win) == N_IRQ - 1) ptr_d = '0;
            else                        ptr_d = win + PW'(1);
        end

        // A new event in the same cycle as its clear wins, so nothing is lost.
        pending_d = set_v | (pending_q & ~clr_v);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            irq_q     <= '0;
            pending_q <= '0;
            req_q     <= 1'b0;
            num_q     <= '0;
            ptr_q     <= '0;
`ifdef PCIE_MSI_ARB_HOLDOFF_EN
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            irq_q     <= irq_d;
            pending_q <= pending_d;
            req_q     <= req_d;
            num_q     <= num_d;
            ptr_q     <= ptr_d;
`ifdef PCIE_MSI_ARB_HOLDOFF_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_pcie_msi_arb.sv
// Purpose: directed bench for pcie_msi_arb with a queue of expected MSI vector numbers.
// Latency: inputs driven 1 time unit after each rising edge, outputs sampled there too.
// Backpressure: the bench acts as the hard IP, holding ack off for a chosen number of cycles.

module tb_pcie_msi_arb;

    localparam int          N      = 8;
    localparam logic [31:0] LEVEL  = 32'h0000_0001;
    localparam logic [2:0]  TC     = 3'd5;
    localparam int          HOLD   = 16;
`ifdef PCIE_MSI_ARB_HOLDOFF_EN
    localparam int          GAP    = HOLD;
`else
    localparam int          GAP    = 1;
`endif

    logic         clk;
    logic         reset;
    logic [N-1:0] irq;
    logic [N-1:0] irq_mask;
    logic         msi_enable;
    logic [2:0]   msi_mme;
    logic         app_msi_req;
    logic [4:0]   app_msi_num;
    logic [2:0]   app_msi_tc;
    logic         app_msi_ack;
    logic         app_int_sts;
    logic         app_int_ack;
    logic [N-1:0] irq_pending;

    int checks   = 0;
    int failures = 0;
    int exp_q[$];

    pcie_msi_arb #(
        .N_IRQ          (N),
        .IRQ_LEVEL      (LEVEL),
        .MSI_TC         (TC),
        .HOLDOFF_CYCLES (HOLD)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .irq         (irq),
        .irq_mask    (irq_mask),
        .msi_enable  (msi_enable),
        .msi_mme     (msi_mme),
        .app_msi_req (app_msi_req),
        .app_msi_num (app_msi_num),
        .app_msi_tc  (app_msi_tc),
        .app_msi_ack (app_msi_ack),
        .app_int_sts (app_int_sts),
        .app_int_ack (app_int_ack),
        .irq_pending (irq_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        exp_q.delete();
        tick();
    endtask

    task automatic pulse(input logic [N-1:0] bits);
        irq = irq | bits;
        tick();
        irq = irq & ~bits;
    endtask

    // Wait for a request, compare against the scoreboard, hold it, then acknowledge.
    // rel clears irq bits and pls pulses irq bits in the ack cycle.
    task automatic serve(input string tag, input int hold,
                         input logic [N-1:0] rel, input logic [N-1:0] pls);
        int w = 0;
        int e;
        while (app_msi_req !== 1'b1 && w < 40) begin
            tick();
            w++;
        end
        check({tag, "_req"}, 32'(app_msi_req), 32'd1);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 99;
        check({tag, "_num"}, 32'(app_msi_num), 32'(e));
        repeat (hold) tick();
        check({tag, "_hold"}, {27'd0, app_msi_req, app_msi_num}, {27'd0, 1'b1, 5'(e)});
        app_msi_ack = 1'b1;
        irq = (irq & ~rel) | pls;
        tick();
        app_msi_ack = 1'b0;
        irq = irq & ~pls;
        check({tag, "_drop"}, 32'(app_msi_req), 32'd0);
    endtask

    task automatic no_req(input string tag, input int cycles);
        logic seen = 1'b0;
        repeat (cycles) begin
            tick();
            seen = seen | app_msi_req;
        end
        check(tag, 32'(seen), 32'd0);
    endtask

    initial begin
        int w;
        reset       = 1'b1;
        irq         = '0;
        irq_mask    = '0;
        msi_enable  = 1'b1;
        msi_mme     = 3'd3;
        app_msi_ack = 1'b0;
        app_int_ack = 1'b0;
        #2;
        check("rst_req",  32'(app_msi_req), 32'd0);
        check("rst_num",  32'(app_msi_num), 32'd0);
        check("rst_pend", 32'(irq_pending), 32'd0);
        check("tc",       32'(app_msi_tc),  32'(TC));
        check("int_sts",  32'(app_int_sts), 32'd0);
        do_reset();

        // Single edge pulse on source 2: latency and one MSI only.
        pulse(8'h04);
        exp_q.push_back(2);
        check("t1_pend", 32'(irq_pending), 32'h04);
        check("t1_early", 32'(app_msi_req), 32'd0);
        tick();
        check("t1_lat", 32'(app_msi_req), 32'd1);
        serve("t1", 5, '0, '0);
        check("t1_clr", 32'(irq_pending), 32'd0);
        no_req("t1_once", 6);

        // Sources 1 and 5 together from pointer 0; then pointer 2 with both again.
        do_reset();
        pulse(8'h22);
        exp_q.push_back(1);
        exp_q.push_back(5);
        serve("t2a", 2, '0, '0);
        w = 0;
        while (app_msi_req !== 1'b1 && w < 40) begin
            tick();
            w++;
        end
        check("t2_gap", 32'(w), 32'(GAP));
        serve("t2b", 1, '0, '0);
        do_reset();
        pulse(8'h02);
        exp_q.push_back(1);
        serve("t2c", 1, '0, '0);
        tick();
        pulse(8'h22);
        exp_q.push_back(5);
        exp_q.push_back(1);
        serve("t2d", 1, '0, '0);
        serve("t2e", 1, '0, '0);
        no_req("t2_idle", 4);

        // Two vectors granted: sources 3 and 6 fold onto vector 1 and clear together.
        do_reset();
        msi_mme = 3'd1;
        pulse(8'h48);
        exp_q.push_back(1);
        serve("t3", 2, '0, '0);
        check("t3_clr", 32'(irq_pending), 32'd0);
        no_req("t3_once", 5);

        // One vector granted and an out-of-range MME value.
        do_reset();
        msi_mme = 3'd0;
        pulse(8'h80);
        exp_q.push_back(0);
        serve("t3z", 1, '0, '0);
        msi_mme = 3'd7;
        pulse(8'h40);
        exp_q.push_back(6);
        serve("t3m", 1, '0, '0);
        msi_mme = 3'd3;

        // Level source 0 held through three acks, released with the third.
        do_reset();
        irq[0] = 1'b1;
        repeat (3) exp_q.push_back(0);
        serve("t4a", 1, '0, '0);
        serve("t4b", 1, '0, '0);
        serve("t4c", 1, 8'h01, '0);
        check("t4_clr", 32'(irq_pending), 32'd0);
        no_req("t4_rel", 5);

        // Masked level source pends but does not request until unmasked.
        irq_mask[0] = 1'b1;
        irq[0]      = 1'b1;
        no_req("t4_mask", 4);
        check("t4_mpend", 32'(irq_pending[0]), 32'd1);
        irq_mask[0] = 1'b0;
        exp_q.push_back(0);
        serve("t4u", 1, 8'h01, '0);
        check("t4u_clr", 32'(irq_pending), 32'd0);

        // New edge on source 4 in the ack cycle for vector 4 is not lost.
        do_reset();
        pulse(8'h10);
        exp_q.push_back(4);
        exp_q.push_back(4);
        serve("t5a", 2, '0, 8'h10);
        check("t5_keep", 32'(irq_pending), 32'h10);
        serve("t5b", 1, '0, '0);
        check("t5_clr", 32'(irq_pending), 32'd0);

        // MSI Enable dropped mid-request: request completes, later events only pend.
        do_reset();
        pulse(8'h04);
        exp_q.push_back(2);
        tick();
        check("t6_req", 32'(app_msi_req), 32'd1);
        msi_enable = 1'b0;
        serve("t6a", 2, '0, '0);
        pulse(8'h08);
        no_req("t6_dis", 5);
        check("t6_pend", 32'(irq_pending), 32'h08);
        msi_enable = 1'b1;
        exp_q.push_back(3);
        serve("t6b", 1, '0, '0);

        // Reset during an outstanding request drops it without a clock edge.
        do_reset();
        pulse(8'h08);
        tick();
        check("t7_req", 32'(app_msi_req), 32'd1);
        reset = 1'b1;
        #1;
        check("t7_req0", 32'(app_msi_req), 32'd0);
        check("t7_num0", 32'(app_msi_num), 32'd0);
        check("t7_pend0", 32'(irq_pending), 32'd0);
        tick();
        reset = 1'b0;
        no_req("t7_quiet", 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
